// File: rtl/ddr3_mover_pkg.sv
// Shared types and helpers for the DDR3 burst mover: FSM state, grant tracking,
// MIG command encodings and the wrapping address advance.
package ddr3_mover_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN
    } state_t;

    typedef enum logic {
        GRANT_WRITE,
        GRANT_READ
    } grant_t;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    // Step an address by incr and fold it back to 0 once it reaches limit.
    function automatic logic [63:0] addr_advance(input logic [63:0] addr,
                                                 input logic [63:0] incr,
                                                 input logic [63:0] limit);
        logic [63:0] nxt;
        nxt = addr + incr;
        return (nxt >= limit) ? 64'd0 : nxt;
    endfunction

endpackage

// File: rtl/ddr3_burst_mover_if.sv
// MIG DDR3 user-interface bundle; the mover drives it as master, the MIG
// controller (or its model) sits on the slave side.
interface ddr3_burst_mover_if #(
    parameter int ADDR_WIDTH = 30,
    parameter int DATA_WIDTH = 128
);
    logic                    app_rdy;
    logic                    app_wdf_rdy;
    logic                    app_en;
    logic [2:0]              app_cmd;
    logic [ADDR_WIDTH-1:0]   app_addr;
    logic                    app_wdf_wren;
    logic                    app_wdf_end;
    logic [DATA_WIDTH-1:0]   app_wdf_data;
    logic [DATA_WIDTH/8-1:0] app_wdf_mask;
    logic [DATA_WIDTH-1:0]   app_rd_data;
    logic                    app_rd_data_valid;
    logic                    app_rd_data_end;

    modport master (
        input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
        output app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end, app_wdf_data,
               app_wdf_mask
    );

    modport slave (
        output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
        input  app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end, app_wdf_data,
               app_wdf_mask
    );
endinterface

// File: rtl/ddr3_addr_ptr.sv
// Linear DDR3 address pointer: advances by ADDR_INCR on inc, returns to 0 at
// ADDR_LIMIT and pulses wrap in the cycle whose increment folds it back.
module ddr3_addr_ptr
    import ddr3_mover_pkg::*;
#(
    parameter int          ADDR_WIDTH = 30,
    parameter int unsigned ADDR_INCR  = 8,
    parameter int unsigned ADDR_LIMIT = 32'h0800_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] ptr,
    output logic                  wrap
);

    logic [ADDR_WIDTH-1:0] ptr_nxt;

    assign ptr_nxt = ADDR_WIDTH'(addr_advance(64'(ptr), 64'(ADDR_INCR), 64'(ADDR_LIMIT)));
    assign wrap    = inc & (ptr_nxt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (inc) begin
            // NOTE: non-blocking so every register in the design samples pre-edge values.
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/ddr3_burst_mover.sv
// Moves inbound FIFO words into DDR3 as single-beat write bursts and streams
// them back, in the same linear order, into the outbound FIFO.
module ddr3_burst_mover
    import ddr3_mover_pkg::*;
#(
    parameter int          ADDR_WIDTH = 30,
    parameter int          DATA_WIDTH = 128,
    parameter int unsigned BURST_LEN  = 32,
    parameter int unsigned ADDR_INCR  = 8,
    parameter int unsigned ADDR_LIMIT = 32'h0800_0000,
    parameter int unsigned OB_DEPTH   = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  writes_en,
    input  logic                  reads_en,
    input  logic                  calib_done,
    input  logic [DATA_WIDTH-1:0] ib_data,
    input  logic                  ib_valid,
    input  logic                  ib_empty,
    input  logic [7:0]            ib_count,
    output logic                  ib_re,
    output logic                  ob_we,
    output logic [DATA_WIDTH-1:0] ob_data,
    input  logic [7:0]            ob_count,
    input  logic                  ob_full,
    ddr3_burst_mover_if.master    app,
    output logic                  busy,
    output logic                  ob_overflow
);

    localparam int unsigned BC_W        = $clog2(BURST_LEN) + 1;
    localparam int unsigned RD_HEADROOM = OB_DEPTH - 2 * BURST_LEN;

    state_t                state;
    grant_t                last_grant;
    logic [BC_W-1:0]       beat_cnt;
    logic [BC_W-1:0]       outstanding;
    logic [BC_W-1:0]       outstanding_nxt;
    logic                  lapped;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  wr_wrap;
    logic                  rd_wrap;
    logic                  wr_qual;
    logic                  rd_qual;
    logic                  wr_beat;
    logic                  rd_issue;
    logic                  rd_ret;
    logic                  unused_inputs;

    // FWFT status and read-data end are implied by valid with single-beat commands.
    assign unused_inputs = ^{ib_empty, app.app_rd_data_end};

    ddr3_addr_ptr #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ADDR_INCR  (ADDR_INCR),
        .ADDR_LIMIT (ADDR_LIMIT)
    ) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (wr_beat),
        .ptr   (wr_ptr),
        .wrap  (wr_wrap)
    );

    ddr3_addr_ptr #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ADDR_INCR  (ADDR_INCR),
        .ADDR_LIMIT (ADDR_LIMIT)
    ) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (rd_issue),
        .ptr   (rd_ptr),
        .wrap  (rd_wrap)
    );

    // Reads may only start when DDR3 holds unread data and the outbound FIFO
    // can absorb two full bursts.
    assign wr_qual = calib_done & writes_en & (32'(ib_count) >= BURST_LEN);
    assign rd_qual = calib_done & reads_en & (32'(ob_count) <= RD_HEADROOM)
                   & ((rd_ptr != wr_ptr) | lapped);

    assign wr_beat  = (state == ST_WRITE) & ib_valid & app.app_wdf_rdy & app.app_rdy;
    assign rd_issue = (state == ST_READ) & app.app_rdy;
    assign rd_ret   = app.app_rd_data_valid & ((state == ST_READ) | (state == ST_DRAIN));

    assign app.app_en       = wr_beat | (state == ST_READ);
    assign app.app_cmd      = (state == ST_READ) ? CMD_READ : CMD_WRITE;
    assign app.app_addr     = (state == ST_READ) ? rd_ptr : wr_ptr;
    assign app.app_wdf_wren = wr_beat;
    assign app.app_wdf_end  = wr_beat;
    assign app.app_wdf_data = (state == ST_WRITE) ? ib_data : '0;
    assign app.app_wdf_mask = '0;

    assign ib_re   = wr_beat;
    assign ob_we   = rd_ret;
    assign ob_data = rd_ret ? app.app_rd_data : '0;
    assign busy    = (state != ST_IDLE);

    always_comb begin
        // NOTE: default first so no branch leaves outstanding_nxt unassigned (no latch).
        outstanding_nxt = outstanding;
        unique case ({rd_issue, rd_ret})
            2'b10:   outstanding_nxt = outstanding + BC_W'(1);
            2'b01:   outstanding_nxt = outstanding - BC_W'(1);
            default: outstanding_nxt = outstanding;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: only control state is reset; the data path is pass-through and holds nothing.
            state       <= ST_IDLE;
            last_grant  <= GRANT_READ;
            beat_cnt    <= '0;
            outstanding <= '0;
            lapped      <= 1'b0;
            ob_overflow <= 1'b0;
        end else begin
            outstanding <= outstanding_nxt;

            if (wr_wrap) begin
                lapped <= 1'b1;
            end else if (rd_wrap) begin
                lapped <= 1'b0;
            end

            if (rd_ret && ob_full) begin
                ob_overflow <= 1'b1;
            end

            unique case (state)
                ST_IDLE: begin
                    if (wr_qual && (!rd_qual || last_grant == GRANT_READ)) begin
                        state      <= ST_WRITE;
                        last_grant <= GRANT_WRITE;
                        beat_cnt   <= BC_W'(BURST_LEN);
                    end else if (rd_qual) begin
                        state      <= ST_READ;
                        last_grant <= GRANT_READ;
                        beat_cnt   <= BC_W'(BURST_LEN);
                    end
                end
                ST_WRITE: begin
                    if (wr_beat) begin
                        beat_cnt <= beat_cnt - BC_W'(1);
                        if (beat_cnt == BC_W'(1)) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_READ: begin
                    if (rd_issue) begin
                        beat_cnt <= beat_cnt - BC_W'(1);
                        if (beat_cnt == BC_W'(1)) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (outstanding_nxt == '0) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr3_burst_mover.sv
// Self-checking bench for ddr3_burst_mover: inbound FIFO and MIG models, a
// read-data scoreboard, a qualification vector table and burst sequences.
module tb_ddr3_burst_mover;
    import ddr3_mover_pkg::*;

    localparam int AW    = 30;
    localparam int DW    = 128;
    localparam int BL    = 32;
    localparam int INCR  = 8;
    localparam int LIMIT = 256;
    localparam int DEPTH = 256;
    localparam int LAT   = 20;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          writes_en, reads_en, calib_done;
    logic [DW-1:0] ib_data;
    logic          ib_valid, ib_empty, ib_re;
    logic [7:0]    ib_count, ob_count;
    logic          ob_we, ob_full, busy, ob_overflow;
    logic [DW-1:0] ob_data;

    ddr3_burst_mover_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) app ();

    ddr3_burst_mover #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .BURST_LEN  (BL),
        .ADDR_INCR  (INCR),
        .ADDR_LIMIT (LIMIT),
        .OB_DEPTH   (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .writes_en   (writes_en),
        .reads_en    (reads_en),
        .calib_done  (calib_done),
        .ib_data     (ib_data),
        .ib_valid    (ib_valid),
        .ib_empty    (ib_empty),
        .ib_count    (ib_count),
        .ib_re       (ib_re),
        .ob_we       (ob_we),
        .ob_data     (ob_data),
        .ob_count    (ob_count),
        .ob_full     (ob_full),
        .app         (app.master),
        .busy        (busy),
        .ob_overflow (ob_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        int            due;
    } ret_t;

    typedef struct {
        logic       calib;
        logic       wen;
        logic       ren;
        logic [7:0] ibc;
        logic       exp_busy;
    } vec_t;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    int            ib_idx   = 0;
    int            exp_wa   = 0;
    int            exp_ra   = 0;
    int            wbeats   = 0;
    int            rbeats   = 0;
    int            ibre_cnt = 0;
    int            obwe_cnt = 0;
    int            last_obwe_cyc = 0;
    logic          prev_busy = 1'b0;
    logic [DW-1:0] model   [int];
    logic [DW-1:0] mig_mem [int];
    logic [DW-1:0] sb_q    [$];
    ret_t          pend    [$];
    bit            grants  [$];
    vec_t          vecs    [7];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] gen(input int k);
        return {32'hC0DE_0000 ^ 32'(k), ~32'(k), 32'(k * 3), 32'h5A5A_0000 + 32'(k)};
    endfunction

    function automatic void reset_model();
        sb_q.delete();
        exp_wa = 0;
        exp_ra = 0;
    endfunction

    // Inbound FIFO head: FWFT word for the next unpopped index.
    always @(posedge clk) begin
        #1;
        ib_data = gen(ib_idx);
    end

    // MIG read-data return path with fixed latency.
    always @(posedge clk) begin
        ret_t r;
        cyc++;
        #1;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            r = pend.pop_front();
            app.app_rd_data       = r.d;
            app.app_rd_data_valid = 1'b1;
            app.app_rd_data_end   = 1'b1;
        end else begin
            app.app_rd_data       = '0;
            app.app_rd_data_valid = 1'b0;
            app.app_rd_data_end   = 1'b0;
        end
    end

    // Mid-cycle monitor: MIG/FIFO handshakes and the read-data scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ib_re) ibre_cnt++;
            if (app.app_en && app.app_cmd == CMD_WRITE) begin
                check("wr_qual", {ib_valid, app.app_rdy, app.app_wdf_rdy}, 3'b111);
                check("wr_strobes", {app.app_wdf_wren, app.app_wdf_end, ib_re}, 3'b111);
                check("wr_addr", app.app_addr, exp_wa);
                check("wr_data", app.app_wdf_data, gen(ib_idx));
                model[exp_wa]               = gen(ib_idx);
                mig_mem[int'(app.app_addr)] = app.app_wdf_data;
                exp_wa = (exp_wa + INCR) % LIMIT;
                ib_idx++;
                wbeats++;
            end else begin
                check("wr_idle", {app.app_wdf_wren, app.app_wdf_end, ib_re}, 3'b000);
            end
            if (app.app_en && app.app_cmd == CMD_READ && app.app_rdy) begin
                check("rd_addr", app.app_addr, exp_ra);
                sb_q.push_back(model.exists(exp_ra) ? model[exp_ra] : '0);
                pend.push_back('{d: (mig_mem.exists(int'(app.app_addr)) ?
                                     mig_mem[int'(app.app_addr)] : '0),
                                 due: cyc + 1 + LAT});
                exp_ra = (exp_ra + INCR) % LIMIT;
                rbeats++;
            end
            if (ob_we) begin
                obwe_cnt++;
                last_obwe_cyc = cyc;
                if (sb_q.size() == 0) check("ob_we_unexpected", 1'b1, 1'b0);
                else                  check("ob_data", ob_data, sb_q.pop_front());
            end
            if (busy && !prev_busy) grants.push_back(app.app_cmd == CMD_READ);
            prev_busy = busy;
        end else begin
            prev_busy = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_level(input string name, input logic lvl, input int budget);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (busy !== lvl && t < budget);
        if (busy !== lvl) check(name, busy, lvl);
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_ctrl", {app.app_en, app.app_wdf_wren, app.app_wdf_end, ib_re, ob_we,
                           busy, ob_overflow, app.app_cmd}, 0);
        check("rst_bus", {app.app_addr, app.app_wdf_mask}, 0);
        check("rst_data", app.app_wdf_data | ob_data, 0);
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int t;
        int rb;

        vecs[0] = '{calib: 1'b0, wen: 1'b1, ren: 1'b0, ibc: 8'd32,  exp_busy: 1'b0};
        vecs[1] = '{calib: 1'b1, wen: 1'b0, ren: 1'b0, ibc: 8'd32,  exp_busy: 1'b0};
        vecs[2] = '{calib: 1'b1, wen: 1'b1, ren: 1'b0, ibc: 8'd31,  exp_busy: 1'b0};
        vecs[3] = '{calib: 1'b1, wen: 1'b1, ren: 1'b0, ibc: 8'd32,  exp_busy: 1'b1};
        vecs[4] = '{calib: 1'b1, wen: 1'b1, ren: 1'b0, ibc: 8'd255, exp_busy: 1'b1};
        vecs[5] = '{calib: 1'b1, wen: 1'b0, ren: 1'b1, ibc: 8'd0,   exp_busy: 1'b0};
        vecs[6] = '{calib: 1'b1, wen: 1'b1, ren: 1'b1, ibc: 8'd32,  exp_busy: 1'b1};

        rst_n = 1'b0;
        writes_en = 1'b0; reads_en = 1'b0; calib_done = 1'b0;
        ib_valid = 1'b1; ib_empty = 1'b0; ib_count = 8'd0;
        ob_count = 8'd0; ob_full = 1'b0;
        app.app_rdy = 1'b0; app.app_wdf_rdy = 1'b0;
        app.app_rd_data = '0; app.app_rd_data_valid = 1'b0; app.app_rd_data_end = 1'b0;

        // Qualification table; readies low so granted bursts stall, next reset aborts them.
        for (int i = 0; i < 7; i++) begin
            do_reset();
            calib_done = vecs[i].calib;
            writes_en  = vecs[i].wen;
            reads_en   = vecs[i].ren;
            ib_count   = vecs[i].ibc;
            tick(2);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
            check($sformatf("vec%0d_cmd_en", i), {app.app_cmd, app.app_en}, {CMD_WRITE, 1'b0});
        end
        do_reset();
        writes_en = 1'b0; reads_en = 1'b0;

        // Burst 1: 32 back-to-back writes with all readies high.
        calib_done = 1'b1; ib_count = 8'd32;
        app.app_rdy = 1'b1; app.app_wdf_rdy = 1'b1;
        wbeats = 0; ibre_cnt = 0;
        writes_en = 1'b1;
        wait_level("w1_rise", 1'b1, 20);
        t0 = cyc;
        writes_en = 1'b0;
        wait_level("w1_fall", 1'b0, 100);
        check("w1_cycles", cyc - t0, BL);
        check("w1_beats", wbeats, BL);
        check("w1_ib_re", ibre_cnt, BL);

        // Read the burst back through 20-cycle latency, with a short app_rdy stall.
        rbeats = 0; obwe_cnt = 0;
        reads_en = 1'b1;
        wait_level("r1_rise", 1'b1, 20);
        reads_en = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        app.app_rdy = 1'b0;
        @(negedge clk);
        #1;
        check("rd_en_no_rdy", {app.app_en, app.app_cmd}, {1'b1, CMD_READ});
        rb = rbeats;
        @(negedge clk);
        #1;
        check("rd_stall_hold", rbeats, rb);
        app.app_rdy = 1'b1;
        wait_level("r1_fall", 1'b0, 200);
        check("r1_cmds", rbeats, BL);
        check("r1_ob_we", obwe_cnt, BL);
        check("r1_busy_fall", cyc, last_obwe_cyc + 1);
        check("r1_sb_empty", sb_q.size(), 0);
        check("ovf_clear", ob_overflow, 1'b0);

        // Burst 2: app_wdf_rdy low for burst cycles 5..9.
        wbeats = 0; ibre_cnt = 0;
        writes_en = 1'b1;
        wait_level("w2_rise", 1'b1, 20);
        t0 = cyc;
        writes_en = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        app.app_wdf_rdy = 1'b0;
        for (int k = 5; k <= 9; k++) begin
            @(negedge clk);
            #1;
            check("wstall_quiet", {app.app_en, ib_re}, 2'b00);
            check("wstall_hold", wbeats, 4);
        end
        app.app_wdf_rdy = 1'b1;
        wait_level("w2_fall", 1'b0, 100);
        check("w2_cycles", cyc - t0, BL + 5);
        check("w2_beats", wbeats, BL);
        check("w2_ib_re", ibre_cnt, BL);

        // Outbound headroom boundary: 193 blocks the read, 192 admits it.
        reads_en = 1'b1; ob_count = 8'd193;
        repeat (6) @(negedge clk);
        check("ob_thresh_193", busy, 1'b0);
        ob_count = 8'd192;
        rbeats = 0;
        wait_level("ob_thresh_192", 1'b1, 20);
        reads_en = 1'b0; ob_count = 8'd0;
        wait_level("r2_fall", 1'b0, 200);
        check("r2_cmds", rbeats, BL);

        // Both enabled: grants must alternate W, R, W, R.
        grants.delete();
        writes_en = 1'b1; reads_en = 1'b1;
        t = 0;
        while (grants.size() < 4 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        writes_en = 1'b0; reads_en = 1'b0;
        wait_level("alt_fall", 1'b0, 200);
        check("alt_count", grants.size(), 4);
        for (int g = 0; g < 4 && g < grants.size(); g++)
            check($sformatf("alt_grant%0d", g), grants[g], g % 2);

        // Two write bursts lap the 256-byte window; read must proceed with rd_ptr == wr_ptr.
        wbeats = 0;
        writes_en = 1'b1;
        wait_level("lap_w1_rise", 1'b1, 20);
        wait_level("lap_w1_fall", 1'b0, 100);
        wait_level("lap_w2_rise", 1'b1, 20);
        writes_en = 1'b0;
        wait_level("lap_w2_fall", 1'b0, 100);
        check("lap_beats", wbeats, 2 * BL);
        check("ovf_pre", ob_overflow, 1'b0);
        rbeats = 0; obwe_cnt = 0;
        ob_full = 1'b1;
        reads_en = 1'b1;
        wait_level("lap_read_rise", 1'b1, 20);
        reads_en = 1'b0;
        wait_level("lap_read_fall", 1'b0, 200);
        check("lap_read_cmds", rbeats, BL);
        check("lap_full_pushed", obwe_cnt, BL);
        check("ovf_set", ob_overflow, 1'b1);
        ob_full = 1'b0;

        // Reset mid-READ with about ten commands outstanding.
        writes_en = 1'b1;
        wait_level("mr_w_rise", 1'b1, 20);
        writes_en = 1'b0;
        wait_level("mr_w_fall", 1'b0, 100);
        rbeats = 0;
        reads_en = 1'b1;
        wait_level("mr_r_rise", 1'b1, 20);
        reads_en = 1'b0;
        t = 0;
        while (rbeats < 10 && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("mr_issued", rbeats >= 10, 1'b1);
        do_reset();
        obwe_cnt = 0;
        repeat (40) @(negedge clk);
        check("mr_no_ob_we", obwe_cnt, 0);
        check("mr_idle", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
